// File: rtl/pll_ce_gen.sv
// Fractional clock-enable generator: NUM_CH accumulator channels on refclk, each
// producing mul pulses every div cycles, phase-aligned whenever lock is (re)acquired.
module pll_ce_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 64,
  parameter int DEF_MUL     = 6,
  parameter int DEF_DIV     = 25,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W      = $clog2(LOCK_CYCLES)
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_mul,
  input  logic [ACC_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk_ce,
  output logic              locked
);

  typedef enum logic {RELOCK, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [NUM_CH-1:0]  ce_q, ce_d;
  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [ACC_W-1:0]   acc_d [NUM_CH];
  logic [ACC_W-1:0]   mul_q [NUM_CH];
  logic [ACC_W-1:0]   div_q [NUM_CH];
  logic [ACC_W:0]     sum   [NUM_CH];
  logic               cfg_ok;
  logic               accept;

  assign cfg_ok    = (cfg_div != '0) && (cfg_mul <= cfg_div) && (int'(cfg_ch) < NUM_CH);
  assign cfg_ready = locked_q;
  assign cfg_err   = err_q;
  assign outclk_ce = ce_q;
  assign locked    = locked_q;

  // Next-state logic: the relock timer, config acceptance, and the per-channel
  // accumulators (sum is one bit wider so acc+mul never wraps before the compare).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    ce_d     = '0;
    accept   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c] = acc_q[c];
      sum[c]   = {1'b0, acc_q[c]} + {1'b0, mul_q[c]};
    end
    unique case (state_q)
      RELOCK: begin
        if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
          cnt_d    = '0;
          for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (cfg_valid && cfg_ok) begin
          accept   = 1'b1;
          state_d  = RELOCK;
          locked_d = 1'b0;
          cnt_d    = '0;
        end else begin
          err_d = cfg_valid;
          for (int c = 0; c < NUM_CH; c++) begin
            if (sum[c] >= {1'b0, div_q[c]}) begin
              acc_d[c] = ACC_W'(sum[c] - {1'b0, div_q[c]});
              ce_d[c]  = 1'b1;
            end else begin
              acc_d[c] = sum[c][ACC_W-1:0];
            end
          end
        end
      end
    endcase
  end

  // State and datapath registers; reset restores the default ratio on every channel.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RELOCK;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ce_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        mul_q[c] <= ACC_W'(DEF_MUL);
        div_q[c] <= ACC_W'(DEF_DIV);
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ce_q     <= ce_d;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
        if (accept && (cfg_ch == CH_W'(c))) begin
          mul_q[c] <= cfg_mul;
          div_q[c] <= cfg_div;
        end
      end
    end
  end

endmodule
